qdivs: RTL and testbench

- Sequential signed-magnitude fixed-point divider. Companion to the team's shift-add multiplier: performs the inverse operation on the same Q-format operands.
- Number format: bit N-1 is the sign; bits N-2:0 are the magnitude, with Q fractional bits.
- Restoring division, one quotient bit per clock.
- Used wherever datapath blocks need a/b without a combinational divider; shares the start/complete handshake of the multiplier.

---
 rtl/qdivs_if.sv | 33 +++
 rtl/qdivs.sv | 139 +++++++++++++
 tb/tb_qdivs.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/qdivs_if.sv
// qdivs operand/result bundle.
// The requester holds the master side, the divider the slave side.
interface qdivs_if #(
    parameter int N = 32
);
    logic [N-1:0] i_dividend;
    logic [N-1:0] i_divisor;
    logic         i_start;
    logic [N-1:0] o_quotient_out;
    logic         o_complete;
    logic         o_overflow;
    logic         o_div_by_zero;

    modport master (
        output i_dividend,
        output i_divisor,
        output i_start,
        input  o_quotient_out,
        input  o_complete,
        input  o_overflow,
        input  o_div_by_zero
    );

    modport slave (
        input  i_dividend,
        input  i_divisor,
        input  i_start,
        output o_quotient_out,
        output o_complete,
        output o_overflow,
        output o_div_by_zero
    );
endinterface

// File: rtl/qdivs.sv
// Sequential signed-magnitude Q-format restoring divider.
// One quotient bit per clock, N-1+Q iterations per divide.
module qdivs #(
    parameter int Q = 15,
    parameter int N = 32
) (
    input  logic   i_clk,
    input  logic   i_rst,
    qdivs_if.slave bus
);
    localparam int W  = N - 1 + Q;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DBZ
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           start_ok;
    logic           last;

    logic [W-1:0]   dvd;
    logic [N-2:0]   b;
    logic [N-1:0]   rem;
    // Holds the W-1 newest quotient bits; the full W-bit value
    // only exists as q_nxt on the final iteration.
    logic [W-2:0]   quo;
    logic [CW-1:0]  cnt;
    logic           sign;

    logic [N-1:0]   quot_out;
    logic           ovf;
    logic           dbz;

    logic [N-1:0]   r;
    logic [N:0]     sub;
    logic           ge;
    logic [N-1:0]   rem_nxt;
    logic [W-1:0]   q_nxt;

    // One restoring step: shift in the next dividend bit, trial subtract.
    always_comb begin
        r       = {rem[N-2:0], dvd[W-1]};
        sub     = {1'b0, r} - {2'b0, b};
        // A set remainder MSB means the shifted value exceeds any B.
        ge      = rem[N-1] | ~sub[N];
        rem_nxt = ge ? sub[N-1:0] : r;
        q_nxt   = {quo, ge};
    end

    // State register; reset aborts any division in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; starts are only honoured while idle.
    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        last      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.i_start) begin
                    start_ok = 1'b1;
                    if (bus.i_divisor[N-2:0] == '0) begin
                        state_nxt = S_DBZ;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (cnt == CW'(W - 1)) begin
                    last      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_DBZ: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch, iteration datapath and result registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dvd      <= '0;
            b        <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            sign     <= 1'b0;
            quot_out <= '0;
            ovf      <= 1'b0;
            dbz      <= 1'b0;
        end else begin
            if (start_ok) begin
                dvd  <= {bus.i_dividend[N-2:0], {Q{1'b0}}};
                b    <= bus.i_divisor[N-2:0];
                rem  <= '0;
                quo  <= '0;
                cnt  <= '0;
                sign <= bus.i_dividend[N-1] ^ bus.i_divisor[N-1];
                ovf  <= 1'b0;
                dbz  <= 1'b0;
            end
            if (state == S_RUN) begin
                dvd <= {dvd[W-2:0], 1'b0};
                rem <= rem_nxt;
                quo <= q_nxt[W-2:0];
                cnt <= cnt + 1'b1;
            end
            if (last) begin
                quot_out <= {sign, q_nxt[N-2:0]};
                ovf      <= |q_nxt[W-1:N-1];
            end
            if (state == S_DBZ) begin
                quot_out <= {sign, {(N-1){1'b1}}};
                ovf      <= 1'b1;
                dbz      <= 1'b1;
            end
        end
    end

    assign bus.o_quotient_out = quot_out;
    assign bus.o_complete     = (state == S_IDLE);
    assign bus.o_overflow     = ovf;
    assign bus.o_div_by_zero  = dbz;
endmodule

// File: tb/tb_qdivs.sv
// Scoreboard bench for qdivs.
// Expected results come from a plain integer-division model.
module tb_qdivs;
    localparam int Q = 15;
    localparam int N = 32;
    localparam int LAT = N - 1 + Q;

    typedef struct {
        logic [N-1:0] q;
        logic         ovf;
        logic         dbz;
        int           lat;
    } exp_t;

    logic i_clk;
    logic i_rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    qdivs_if #(.N(N)) bus ();

    qdivs #(.Q(Q), .N(N)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a,
                                   input logic [N-1:0] d);
        exp_t       e;
        logic [63:0] num;
        logic [63:0] den;
        logic [63:0] quo;
        logic        s;
        s   = a[N-1] ^ d[N-1];
        den = 64'(d[N-2:0]);
        if (den == 0) begin
            e.q   = {s, {(N-1){1'b1}}};
            e.ovf = 1'b1;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            num   = 64'(a[N-2:0]) << Q;
            quo   = num / den;
            e.q   = {s, quo[N-2:0]};
            e.ovf = (quo >> (N - 1)) != 0;
            e.dbz = 1'b0;
            e.lat = LAT;
        end
        return e;
    endfunction

    task automatic compare(input string tag, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_lat"}, 64'(lat), 64'(e.lat));
        chk({tag, "_q"}, 64'(bus.o_quotient_out), 64'(e.q));
        chk({tag, "_ovf"}, 64'(bus.o_overflow), 64'(e.ovf));
        chk({tag, "_dbz"}, 64'(bus.o_div_by_zero), 64'(e.dbz));
    endtask

    // poke: cycle to pulse a stray start; rst_at: cycle to reset.
    task automatic do_op(input string tag, input logic [N-1:0] a,
                         input logic [N-1:0] d, input int poke,
                         input int rst_at);
        int cnt;
        @(negedge i_clk);
        bus.i_dividend = a;
        bus.i_divisor  = d;
        bus.i_start    = 1'b1;
        sb.push_back(model(a, d));
        @(negedge i_clk);
        bus.i_start = 1'b0;
        cnt = 0;
        while (!bus.o_complete && cnt < 200) begin
            cnt++;
            bus.i_start = 1'b0;
            if (cnt == poke) begin
                bus.i_dividend = 32'h0001_0000;
                bus.i_divisor  = 32'h0000_8000;
                bus.i_start    = 1'b1;
            end
            if (cnt == rst_at) begin
                i_rst = 1'b1;
                @(negedge i_clk);
                i_rst = 1'b0;
                chk({tag, "_rst_cmp"}, 64'(bus.o_complete), 1);
                chk({tag, "_rst_q"}, 64'(bus.o_quotient_out), 0);
                chk({tag, "_rst_ovf"}, 64'(bus.o_overflow), 0);
                chk({tag, "_rst_dbz"}, 64'(bus.o_div_by_zero), 0);
                void'(sb.pop_front());
                return;
            end
            @(negedge i_clk);
        end
        bus.i_start = 1'b0;
        if (cnt >= 200) begin
            chk({tag, "_timeout"}, 1, 0);
            void'(sb.pop_front());
            return;
        end
        compare(tag, cnt);
    endtask

    task automatic hold_start();
        logic [N-1:0] da[3];
        logic [N-1:0] dd[3];
        int lat;
        int gap;
        da[0] = 32'h0001_8000; dd[0] = 32'h0001_0000;
        da[1] = 32'h8000_8000; dd[1] = 32'h0001_8000;
        da[2] = 32'h0123_4567; dd[2] = 32'h8000_0123;
        @(negedge i_clk);
        bus.i_dividend = da[0];
        bus.i_divisor  = dd[0];
        bus.i_start    = 1'b1;
        sb.push_back(model(da[0], dd[0]));
        @(negedge i_clk);
        for (int k = 0; k < 3; k++) begin
            lat = 0;
            while (!bus.o_complete && lat < 200) begin
                lat++;
                @(negedge i_clk);
            end
            compare($sformatf("hold%0d", k), lat);
            if (k == 2) begin
                bus.i_start = 1'b0;
            end else begin
                bus.i_dividend = da[k+1];
                bus.i_divisor  = dd[k+1];
                sb.push_back(model(da[k+1], dd[k+1]));
                gap = 0;
                while (bus.o_complete && gap < 10) begin
                    gap++;
                    @(negedge i_clk);
                end
                chk($sformatf("hold%0d_gap", k), 64'(gap), 1);
            end
        end
        @(negedge i_clk);
        @(negedge i_clk);
        chk("hold_stop", 64'(bus.o_complete), 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        i_rst  = 1'b1;
        bus.i_dividend = '0;
        bus.i_divisor  = '0;
        bus.i_start    = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        chk("rst_cmp", 64'(bus.o_complete), 1);
        chk("rst_q", 64'(bus.o_quotient_out), 0);
        chk("rst_ovf", 64'(bus.o_overflow), 0);
        chk("rst_dbz", 64'(bus.o_div_by_zero), 0);

        do_op("3_2", 32'h0001_8000, 32'h0001_0000, -1, -1);
        chk("3_2_lit", 64'(bus.o_quotient_out), 64'h0000_C000);
        do_op("m1_4", 32'h8000_8000, 32'h0002_0000, -1, -1);
        chk("m1_4_lit", 64'(bus.o_quotient_out), 64'h8000_2000);
        do_op("1_3", 32'h0000_8000, 32'h0001_8000, -1, -1);
        chk("1_3_lit", 64'(bus.o_quotient_out), 64'h0000_2AAA);
        do_op("ovf", 32'h4000_0000, 32'h0000_0001, -1, -1);
        do_op("dbz", 32'h0000_8000, 32'h8000_0000, -1, -1);
        chk("dbz_lit", 64'(bus.o_quotient_out), 64'hFFFF_FFFF);
        do_op("poke", 32'h0001_8000, 32'h0001_0000, 10, -1);
        do_op("abort", 32'h0003_0000, 32'h0000_4000, -1, 20);
        do_op("after", 32'h0001_0000, 32'h0000_8000, -1, -1);
        chk("after_lit", 64'(bus.o_quotient_out), 64'h0001_0000);
        for (int i = 0; i < 4; i++) begin
            do_op($sformatf("rnd%0d", i), $urandom,
                  {$urandom_range(1), 31'($urandom_range(1, 32'h7FFFFFFF))},
                  -1, -1);
        end
        hold_start();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
